// File: rtl/bsg_manycore_array_reset_sequencer_if.sv
// ---------------------------------------------------------------------------
// bsg_manycore_array_reset_sequencer_if
//
// Request/status bundle between a reset controller and the array reset
// sequencer. Signal names keep their sequencer-relative direction suffixes so
// they line up with the legacy port list.
//
//   req_v_i      requester -> sequencer  request a reset sequence
//   col_mask_i   requester -> sequencer  columns to reset, sampled on accept
//   req_ready_o  sequencer -> requester  sequencer idle, request accepted
//   busy_o       sequencer -> requester  sequence in progress
//   done_o       sequencer -> requester  one-cycle end-of-sequence pulse
//   error_o      sequencer -> requester  sticky propagation timeout
//
// Modports: slave (sequencer side), master (requester side).
// ---------------------------------------------------------------------------
interface bsg_manycore_array_reset_sequencer_if #(
    parameter int num_cols_p = 4
);
    logic                  req_v_i;
    logic                  req_ready_o;
    logic [num_cols_p-1:0] col_mask_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  error_o;

    modport slave (
        input  req_v_i, col_mask_i,
        output req_ready_o, busy_o, done_o, error_o
    );

    modport master (
        output req_v_i, col_mask_i,
        input  req_ready_o, busy_o, done_o, error_o
    );
endinterface

// File: rtl/bsg_manycore_array_reset_sequencer.sv
// ---------------------------------------------------------------------------
// bsg_manycore_array_reset_sequencer
//
// Per-column reset sequencer for a compute-tile subarray. Asserts reset on a
// selected set of columns, holds it, releases the columns west-to-east with a
// programmable stagger, then waits for every selected column's reset to come
// back low from the south edge of the array.
//
// Ports:
//   clk_i          clock
//   reset_n_i      asynchronous active-low reset; starts a power-on sequence
//                  over all columns when released
//   req            request/status bundle (slave modport)
//   array_reset_o  per-column reset to the subarray north edge (registered)
//   array_reset_i  per-column reset returned from the subarray south edge
//
// Optional feature: define BSG_MANYCORE_RESET_SEQ_TIMEOUT_EN to bound the
// WAIT state to prop_timeout_p cycles and raise a sticky error_o on expiry.
// Without it WAIT waits indefinitely and error_o is tied low.
// ---------------------------------------------------------------------------
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

module bsg_manycore_array_reset_sequencer #(
    parameter int num_cols_p     = 4,
    parameter int hold_cycles_p  = 16,
    parameter int stagger_p      = 2,
    parameter int prop_timeout_p = 64
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    bsg_manycore_array_reset_sequencer_if.slave req,
    output logic [num_cols_p-1:0]               array_reset_o,
    input  logic [num_cols_p-1:0]               array_reset_i
);

    if (num_cols_p < 1)     begin : g_bad_cols    $error("num_cols_p must be >= 1");     end
    if (hold_cycles_p < 1)  begin : g_bad_hold    $error("hold_cycles_p must be >= 1");  end
    if (stagger_p < 1)      begin : g_bad_stagger $error("stagger_p must be >= 1");      end
    if (prop_timeout_p < 1) begin : g_bad_timeout $error("prop_timeout_p must be >= 1"); end

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HOLD    = 3'd1;
    localparam logic [2:0] RELEASE = 3'd2;
    localparam logic [2:0] WAIT    = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam int hold_w_lp = `BSG_SAFE_CLOG2(hold_cycles_p);
    localparam int stag_w_lp = `BSG_SAFE_CLOG2(stagger_p);
    localparam int col_w_lp  = `BSG_SAFE_CLOG2(num_cols_p);

    localparam logic [hold_w_lp-1:0] hold_last_lp = hold_w_lp'(hold_cycles_p - 1);
    localparam logic [stag_w_lp-1:0] stag_last_lp = stag_w_lp'(stagger_p - 1);
    localparam logic [col_w_lp-1:0]  col_last_lp  = col_w_lp'(num_cols_p - 1);

    logic [2:0]            state_r;
    logic [num_cols_p-1:0] mask_r;
    logic [num_cols_p-1:0] array_reset_r;
    logic [hold_w_lp-1:0]  hold_cnt_r;
    logic [stag_w_lp-1:0]  stag_cnt_r;
    logic [col_w_lp-1:0]   col_idx_r;
    logic                  done_r;
    logic                  error_r;

    logic                  accept;
    logic                  col_done;
    logic                  col_last;
    logic [col_w_lp-1:0]   col_next;
    logic                  wait_unmet;

    assign accept     = (state_r == IDLE) && req.req_v_i;
    // Unmasked columns are skipped in one cycle; masked ones occupy stagger_p.
    assign col_done   = !mask_r[col_idx_r] || (stag_cnt_r == stag_last_lp);
    assign col_last   = (col_idx_r == col_last_lp);
    assign col_next   = col_idx_r + 1'b1;
    assign wait_unmet = |(array_reset_i & mask_r);

`ifdef BSG_MANYCORE_RESET_SEQ_TIMEOUT_EN
    localparam int to_w_lp = `BSG_SAFE_CLOG2(prop_timeout_p);
    localparam logic [to_w_lp-1:0] to_last_lp = to_w_lp'(prop_timeout_p - 1);

    logic [to_w_lp-1:0] to_cnt_r;
    logic               timeout;

    assign timeout = (state_r == WAIT) && wait_unmet && (to_cnt_r == to_last_lp);

    // to_cnt only advances while WAIT is still unmet and below its limit, so
    // it never wraps; it returns to zero whenever the FSM is outside WAIT.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            to_cnt_r <= '0;
            error_r  <= 1'b0;
        end else begin
            if (accept)
                error_r <= 1'b0;
            else if (timeout)
                error_r <= 1'b1;

            if (state_r != WAIT)
                to_cnt_r <= '0;
            else if (wait_unmet && !timeout)
                to_cnt_r <= to_cnt_r + 1'b1;
        end
    end
`else
    assign error_r = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r       <= HOLD;
            mask_r        <= '1;
            array_reset_r <= '1;
            hold_cnt_r    <= '0;
            stag_cnt_r    <= '0;
            col_idx_r     <= '0;
            done_r        <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept) begin
                        if (|req.col_mask_i) begin
                            mask_r        <= req.col_mask_i;
                            array_reset_r <= array_reset_r | req.col_mask_i;
                            hold_cnt_r    <= '0;
                            state_r       <= HOLD;
                        end else begin
                            // Empty mask: no-op sequence, just acknowledge.
                            done_r <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt_r == hold_last_lp) begin
                        hold_cnt_r <= '0;
                        col_idx_r  <= '0;
                        stag_cnt_r <= '0;
                        state_r    <= RELEASE;
                        // A column's release is registered on the edge that
                        // enters its visit, so column 0 is cleared here.
                        if (mask_r[0])
                            array_reset_r[0] <= 1'b0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + 1'b1;
                    end
                end
                RELEASE: begin
                    if (col_done) begin
                        stag_cnt_r <= '0;
                        if (col_last) begin
                            state_r <= WAIT;
                        end else begin
                            col_idx_r <= col_next;
                            if (mask_r[col_next])
                                array_reset_r[col_next] <= 1'b0;
                        end
                    end else begin
                        stag_cnt_r <= stag_cnt_r + 1'b1;
                    end
                end
                WAIT: begin
                    if (!wait_unmet) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end
`ifdef BSG_MANYCORE_RESET_SEQ_TIMEOUT_EN
                    else if (timeout) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end
`endif
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign array_reset_o   = array_reset_r;
    assign req.req_ready_o = (state_r == IDLE);
    assign req.busy_o      = (state_r != IDLE);
    assign req.done_o      = done_r;
    assign req.error_o     = error_r;

endmodule
